mask_bbox_extractor: RTL and testbench



---
 rtl/mask_bbox_extractor_pkg.sv | 20 ++
 rtl/mask_bbox_extractor_raster_counter.sv | 64 ++++++
 rtl/mask_bbox_extractor.sv | 164 ++++++++++++++++
 tb/tb_mask_bbox_extractor.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mask_bbox_extractor_pkg.sv
// Shared definitions for the mask bounding-box path.
// Latency: n/a (types, constants and a pure helper function only).
// Backpressure: n/a. FG_THRESH is also used by the threshold stage that produces the mask.
package mask_bbox_extractor_pkg;

  // Frame-tracking FSM states.
  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } state_e;

  // A pixel at or above this level counts as foreground. Any clean 255/0 mask
  // classifies exactly, and partially quantised masks still split sensibly.
  localparam logic [7:0] FG_THRESH = 8'd128;

  function automatic logic is_fg(input logic [7:0] px);
    return (px >= FG_THRESH);
  endfunction

endpackage

// File: rtl/mask_bbox_extractor_raster_counter.sv
// Raster position tracker: column/row of the pixel being accepted, plus a flag for the last pixel of the frame.
// Latency: col_o/row_o/last_pix_o are combinational from state and clr_i; the position advances on the enabled edge.
// Backpressure: none; advances exactly once per cycle with en_i=1.
//
// Ports:
//   clk, rst_n  clock, async active-low reset
//   en_i        current pixel is accepted; step to the next raster position
//   clr_i       current pixel is (0,0) of a new frame; overrides the held position
//   col_o       column of the current pixel
//   row_o       row of the current pixel
//   last_pix_o  current pixel is (IMG_W-1, IMG_H-1)
module raster_counter #(
  parameter int IMG_W = 28,
  parameter int IMG_H = 28,
  localparam int CW = $clog2(IMG_W),
  localparam int RW = $clog2(IMG_H)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en_i,
  input  logic          clr_i,
  output logic [CW-1:0] col_o,
  output logic [RW-1:0] row_o,
  output logic          last_pix_o
);

  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;

  always_comb begin
    // A clearing pixel is itself (0,0), so the clear is folded into the
    // presented position rather than costing a cycle.
    col_o      = clr_i ? '0 : col_q;
    row_o      = clr_i ? '0 : row_q;
    last_pix_o = (col_o == CW'(IMG_W - 1)) && (row_o == RW'(IMG_H - 1));

    col_d = col_q;
    row_d = row_q;
    if (en_i) begin
      if (col_o == CW'(IMG_W - 1)) begin
        col_d = '0;
        // Row wrap after the last pixel leaves the counter at (0,0).
        row_d = (row_o == RW'(IMG_H - 1)) ? '0 : row_o + RW'(1);
      end else begin
        col_d = col_o + CW'(1);
        row_d = row_o;
      end
    end else if (clr_i) begin
      col_d = '0;
      row_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q <= '0;
      row_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
    end
  end

endmodule

// File: rtl/mask_bbox_extractor.sv
// Accumulates the foreground bounding box and pixel count of a raster-ordered binary mask frame.
// Latency: results and the one-cycle bbox_valid strobe appear the cycle after the frame's last pixel is accepted.
// Backpressure: none; every cycle with din_valid=1 consumes a pixel.
//
// Ports:
//   clk, rst_n      clock, async active-low reset
//   din_valid       pixel qualifier
//   din_sof         with din_valid, marks pixel (0,0) of a frame
//   din             8-bit mask pixel
//   bbox_valid      one-cycle result strobe
//   bbox_empty      committed frame had no foreground
//   x_min, x_max    inclusive column bounds
//   y_min, y_max    inclusive row bounds
//   fg_count        foreground pixel count
module mask_bbox_extractor
  import mask_bbox_extractor_pkg::*;
#(
  parameter int IMG_W = 28,
  parameter int IMG_H = 28,
  parameter int CW    = $clog2(IMG_W),
  parameter int RW    = $clog2(IMG_H),
  parameter int NW    = $clog2(IMG_W * IMG_H + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          din_valid,
  input  logic          din_sof,
  input  logic [7:0]    din,
  output logic          bbox_valid,
  output logic          bbox_empty,
  output logic [CW-1:0] x_min,
  output logic [CW-1:0] x_max,
  output logic [RW-1:0] y_min,
  output logic [RW-1:0] y_max,
  output logic [NW-1:0] fg_count
);

  // Running accumulators of the frame in progress. 'seen' marks that at least
  // one foreground pixel has loaded the bounds.
  typedef struct packed {
    logic          seen;
    logic [CW-1:0] xmin;
    logic [CW-1:0] xmax;
    logic [RW-1:0] ymin;
    logic [RW-1:0] ymax;
    logic [NW-1:0] cnt;
  } acc_t;

  state_e        state_q, state_d;
  acc_t          acc_q, acc_d;
  logic          commit;

  logic          sof_acc;
  logic          take;
  logic          pix_fg;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic          last_pix;

  logic          bbox_valid_q;
  logic          bbox_empty_q;
  logic [CW-1:0] x_min_q, x_max_q;
  logic [RW-1:0] y_min_q, y_max_q;
  logic [NW-1:0] fg_count_q;

  // A start-of-frame pixel is processed in either state; other pixels only
  // count while a frame is open.
  assign sof_acc = din_valid && din_sof;
  assign take    = din_valid && (din_sof || (state_q == ACCUM));
  assign pix_fg  = is_fg(din);

  raster_counter #(
    .IMG_W (IMG_W),
    .IMG_H (IMG_H)
  ) u_raster (
    .clk        (clk),
    .rst_n      (rst_n),
    .en_i       (take),
    .clr_i      (sof_acc),
    .col_o      (col),
    .row_o      (row),
    .last_pix_o (last_pix)
  );

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    commit  = 1'b0;

    // A new start of frame discards any partial frame; its pixel then
    // accumulates against clean state below.
    if (sof_acc) begin
      acc_d = '0;
    end

    if (take) begin
      if (pix_fg) begin
        if (!acc_d.seen) begin
          acc_d.xmin = col;
          acc_d.xmax = col;
          acc_d.ymin = row;
          acc_d.ymax = row;
        end else begin
          if (col < acc_d.xmin) acc_d.xmin = col;
          if (col > acc_d.xmax) acc_d.xmax = col;
          if (row < acc_d.ymin) acc_d.ymin = row;
          if (row > acc_d.ymax) acc_d.ymax = row;
        end
        acc_d.seen = 1'b1;
        acc_d.cnt  = acc_d.cnt + NW'(1);
      end

      if (last_pix) begin
        commit  = 1'b1;
        state_d = IDLE;
      end else begin
        state_d = ACCUM;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
    end
  end

  // Result registers take the accumulator next-state so the final pixel of the
  // frame is included without an extra cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bbox_valid_q <= 1'b0;
      bbox_empty_q <= 1'b0;
      x_min_q      <= '0;
      x_max_q      <= '0;
      y_min_q      <= '0;
      y_max_q      <= '0;
      fg_count_q   <= '0;
    end else begin
      bbox_valid_q <= commit;
      if (commit) begin
        bbox_empty_q <= !acc_d.seen;
        x_min_q      <= acc_d.seen ? acc_d.xmin : '0;
        x_max_q      <= acc_d.seen ? acc_d.xmax : '0;
        y_min_q      <= acc_d.seen ? acc_d.ymin : '0;
        y_max_q      <= acc_d.seen ? acc_d.ymax : '0;
        fg_count_q   <= acc_d.seen ? acc_d.cnt  : '0;
      end
    end
  end

  assign bbox_valid = bbox_valid_q;
  assign bbox_empty = bbox_empty_q;
  assign x_min      = x_min_q;
  assign x_max      = x_max_q;
  assign y_min      = y_min_q;
  assign y_max      = y_max_q;
  assign fg_count   = fg_count_q;

endmodule

// File: tb/tb_mask_bbox_extractor.sv
// Bench for mask_bbox_extractor on an 8x4 frame: frame-level reference model plus hand-computed results per frame.
// Latency: expects the result strobe the cycle after the last accepted pixel.
// Backpressure: none; the bench inserts din_valid gaps with din_sof/din noise.
module tb_mask_bbox_extractor;

  localparam int W  = 8;
  localparam int H  = 4;
  localparam int N  = W * H;
  localparam int CW = 3;
  localparam int RW = 2;
  localparam int NW = 6;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          din_valid = 1'b0;
  logic          din_sof = 1'b0;
  logic [7:0]    din = 8'd0;
  logic          bbox_valid;
  logic          bbox_empty;
  logic [CW-1:0] x_min, x_max;
  logic [RW-1:0] y_min, y_max;
  logic [NW-1:0] fg_count;

  always #5 clk = ~clk;

  mask_bbox_extractor #(
    .IMG_W (W),
    .IMG_H (H),
    .CW    (CW),
    .RW    (RW),
    .NW    (NW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .din_valid  (din_valid),
    .din_sof    (din_sof),
    .din        (din),
    .bbox_valid (bbox_valid),
    .bbox_empty (bbox_empty),
    .x_min      (x_min),
    .x_max      (x_max),
    .y_min      (y_min),
    .y_max      (y_max),
    .fg_count   (fg_count)
  );

  typedef struct {
    bit empty;
    int xmin;
    int xmax;
    int ymin;
    int ymax;
    int cnt;
  } res_t;

  int   checks = 0;
  int   failures = 0;
  res_t lit_q[$];
  int   lit_total = 0;
  bit   done = 1'b0;

  // ---------------- reference model ----------------
  logic [7:0] pix[N];
  int         idx = 0;
  bit         active = 1'b0;
  bit         exp_strobe = 1'b0;
  res_t       exp_r = '{1'b0, 0, 0, 0, 0, 0};

  // Bounding box of a whole captured frame by direct scan.
  function automatic res_t frame_result();
    res_t r;
    r = '{1'b1, 0, 0, 0, 0, 0};
    for (int y = 0; y < H; y++) begin
      for (int x = 0; x < W; x++) begin
        if (pix[y * W + x] >= 8'd128) begin
          if (r.empty) begin
            r.xmin = x; r.xmax = x; r.ymin = y; r.ymax = y;
            r.empty = 1'b0;
          end else begin
            if (x < r.xmin) r.xmin = x;
            if (x > r.xmax) r.xmax = x;
            if (y < r.ymin) r.ymin = y;
            if (y > r.ymax) r.ymax = y;
          end
          r.cnt = r.cnt + 1;
        end
      end
    end
    return r;
  endfunction

  initial begin
    forever begin
      @(posedge clk);
      exp_strobe = 1'b0;
      if (!rst_n) begin
        active = 1'b0;
        idx    = 0;
        exp_r  = '{1'b0, 0, 0, 0, 0, 0};
      end else if (din_valid) begin
        if (din_sof) begin
          active = 1'b1;
          idx    = 0;
        end
        if (active) begin
          pix[idx] = din;
          idx = idx + 1;
          if (idx == N) begin
            exp_r      = frame_result();
            exp_strobe = 1'b1;
            active     = 1'b0;
          end
        end
      end
    end
  end

  // ---------------- compare process ----------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      failures = failures + 1;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  initial begin
    int   cyc;
    int   strobes;
    res_t l;
    cyc = 0;
    strobes = 0;
    forever begin
      @(posedge clk or negedge rst_n);
      #1;
      if (!rst_n) begin
        chk("rst_valid", 32'(bbox_valid), 32'd0);
        chk("rst_empty", 32'(bbox_empty), 32'd0);
        chk("rst_xmin",  32'(x_min), 32'd0);
        chk("rst_xmax",  32'(x_max), 32'd0);
        chk("rst_ymin",  32'(y_min), 32'd0);
        chk("rst_ymax",  32'(y_max), 32'd0);
        chk("rst_count", 32'(fg_count), 32'd0);
      end else begin
        chk("strobe",    32'(bbox_valid), 32'(exp_strobe));
        chk("empty",     32'(bbox_empty), 32'(exp_r.empty));
        chk("xmin",      32'(x_min), exp_r.xmin);
        chk("xmax",      32'(x_max), exp_r.xmax);
        chk("ymin",      32'(y_min), exp_r.ymin);
        chk("ymax",      32'(y_max), exp_r.ymax);
        chk("count",     32'(fg_count), exp_r.cnt);
        if (bbox_valid === 1'b1) strobes = strobes + 1;
        if (exp_strobe) begin
          if (lit_q.size() == 0) begin
            failures = failures + 1;
            $display("FAIL lit_avail: frame result with no hand-computed expectation at %0t", $time);
          end else begin
            l = lit_q.pop_front();
            chk("lit_empty", 32'(bbox_empty), 32'(l.empty));
            chk("lit_xmin",  32'(x_min), l.xmin);
            chk("lit_xmax",  32'(x_max), l.xmax);
            chk("lit_ymin",  32'(y_min), l.ymin);
            chk("lit_ymax",  32'(y_max), l.ymax);
            chk("lit_count", 32'(fg_count), l.cnt);
          end
        end
      end
      cyc = cyc + 1;
      if (done || cyc > 5000) begin
        if (!done) begin
          failures = failures + 1;
          $display("FAIL timeout: stimulus did not complete within %0d events", cyc);
        end
        chk("strobe_total", strobes, lit_total);
        chk("lit_left", lit_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
      end
    end
  end

  // ---------------- stimulus ----------------
  logic [7:0] frm[N];

  task automatic px(input bit sof, input logic [7:0] d);
    @(negedge clk);
    din_valid = 1'b1;
    din_sof   = sof;
    din       = d;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      din_valid = 1'b0;
      din_sof   = 1'b0;
      din       = 8'd0;
    end
  endtask

  // Invalid cycle with start-of-frame and foreground noise that must be ignored.
  task automatic gap();
    @(negedge clk);
    din_valid = 1'b0;
    din_sof   = 1'b1;
    din       = 8'hFF;
  endtask

  task automatic fill(input logic [7:0] v);
    for (int i = 0; i < N; i++) frm[i] = v;
  endtask

  task automatic setpx(input int x, input int y);
    frm[y * W + x] = 8'hFF;
  endtask

  task automatic send_frame(input bit gaps);
    for (int i = 0; i < N; i++) begin
      if (gaps && i > 0) gap();
      px(i == 0, frm[i]);
    end
  endtask

  task automatic expect_res(input bit e, input int x0, input int x1,
                            input int y0, input int y1, input int c);
    lit_q.push_back('{e, x0, x1, y0, y1, c});
    lit_total = lit_total + 1;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    idle(2);

    // Single foreground pixel, then two back-to-back frames.
    fill(8'd0); setpx(3, 2);
    expect_res(1'b0, 3, 3, 2, 2, 1);
    send_frame(1'b0);
    fill(8'd0);
    expect_res(1'b1, 0, 0, 0, 0, 0);
    send_frame(1'b0);
    fill(8'hFF);
    expect_res(1'b0, 0, 7, 0, 3, 32);
    send_frame(1'b0);
    idle(3);

    // Same frame sent contiguously and then with valid gaps.
    fill(8'd0); setpx(5, 0); setpx(7, 1); setpx(0, 2); setpx(4, 2);
    expect_res(1'b0, 0, 7, 0, 2, 4);
    send_frame(1'b0);
    idle(2);
    expect_res(1'b0, 0, 7, 0, 2, 4);
    send_frame(1'b1);
    idle(3);

    // Partial frame aborted by a new start of frame at pixel 10.
    fill(8'd0); setpx(1, 0);
    for (int i = 0; i < 10; i++) px(i == 0, frm[i]);
    fill(8'd0); setpx(6, 3); setpx(2, 1);
    expect_res(1'b0, 2, 6, 1, 3, 2);
    send_frame(1'b0);
    idle(3);

    // Reset while pixel 15 is on the bus.
    fill(8'hFF);
    for (int i = 0; i < 15; i++) px(i == 0, frm[i]);
    px(1'b0, 8'hFF);
    #2 rst_n = 1'b0;
    @(negedge clk);
    din_valid = 1'b0;
    din_sof   = 1'b0;
    rst_n     = 1'b1;
    for (int i = 0; i < 10; i++) px(1'b0, 8'hFF);
    idle(2);

    // Corner pixels of a fresh frame after reset.
    fill(8'd0); setpx(0, 0); setpx(7, 3);
    expect_res(1'b0, 0, 7, 0, 3, 2);
    send_frame(1'b0);
    idle(4);
    done = 1'b1;
  end

endmodule
